// File: rtl/cache_array_v3.sv
// cache_array_v3 : N-way set-associative tag/data array with valid bits, registered hit
// detection, tree pseudo-LRU victim selection and a sequenced whole-array invalidate.
//
// Optional feature macro: CACHE_PERF_CNT_EN (adds saturating hit_cnt / miss_cnt outputs).
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   lookup_valid/ready          lookup handshake (index + tag)
//   lookup_index, lookup_tag    set to read and tag to compare
//   resp_valid/hit/way/data     registered lookup result, one cycle after accept
//   fill_valid/ready            refill handshake; fill wins over a same-cycle lookup
//   fill_index/tag/data         refill contents
//   fill_way                    victim for fill_index (combinational)
//   inv_req                     pulse: invalidate whole array (honoured only in RUN)
//   busy                        INIT/FLUSH sweep in progress
//   hit_cnt, miss_cnt           response counters (CACHE_PERF_CNT_EN only)
module cache_array_v3 #(
  parameter int WAYS   = 2,
  parameter int SETS   = 1024,
  parameter int TAG_W  = 18,
  parameter int LINE_W = 256,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lookup_valid,
  output logic              lookup_ready,
  input  logic [IDX_W-1:0]  lookup_index,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [WAY_W-1:0]  resp_way,
  output logic [LINE_W-1:0] resp_data,
  input  logic              fill_valid,
  output logic              fill_ready,
  input  logic [IDX_W-1:0]  fill_index,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_data,
  output logic [WAY_W-1:0]  fill_way,
  input  logic              inv_req,
  output logic              busy
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int LVLS   = (WAYS > 1) ? $clog2(WAYS) : 0;

  typedef enum logic [1:0] {ST_INIT = 2'd0, ST_RUN = 2'd1, ST_FLUSH = 2'd2} state_t;

  // Tree PLRU: node n has children 2n+1 / 2n+2; a node bit of 1 points the victim right.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
    logic [WAY_W-1:0] way;
    int node;
    way  = {WAY_W{1'b0}};
    node = 0;
    for (int l = 0; l < LVLS; l++) begin
      way  = (way << 1'b1) | WAY_W'(bits[node]);
      node = (node << 1'b1) + 32'sd1 + int'(bits[node]);
    end
    return way;
  endfunction

  // Make 'way' most recently used: every node on its path points away from it.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                   input logic [WAY_W-1:0]  way);
    logic [PLRU_W-1:0] nb;
    logic dir;
    int node;
    nb   = bits;
    node = 0;
    for (int l = 0; l < LVLS; l++) begin
      dir      = way[LVLS - 32'sd1 - l];
      nb[node] = ~dir;
      node     = (node << 1'b1) + 32'sd1 + int'(dir);
    end
    return nb;
  endfunction

  // Index of the lowest set bit (0 when none set).
  function automatic logic [WAY_W-1:0] lowest_set(input logic [WAYS-1:0] v);
    logic [WAY_W-1:0] r;
    r = {WAY_W{1'b0}};
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (v[i]) r = WAY_W'(i);
    end
    return r;
  endfunction

  // Array storage; only valid bits have a defined state after INIT.
  logic [TAG_W-1:0]  tag_mem   [SETS][WAYS];
  logic [LINE_W-1:0] data_mem  [SETS][WAYS];
  logic [WAYS-1:0]   valid_mem [SETS];
  logic [PLRU_W-1:0] plru_mem  [SETS];

  state_t            state_r, state_nx_s;
  logic [IDX_W-1:0]  cnt_r, cnt_nx_s;
  logic              lookup_fire_s, fill_fire_s, inv_fire_s;
  logic [WAYS-1:0]   match_s;
  logic              hit_s;
  logic [WAY_W-1:0]  hit_way_s;
  logic [WAYS-1:0]   invalid_s;

  assign busy          = (state_r != ST_RUN);
  assign lookup_ready  = (state_r == ST_RUN) && !fill_valid && !inv_req;
  assign fill_ready    = (state_r == ST_RUN) && !inv_req;
  assign lookup_fire_s = lookup_valid && lookup_ready;
  assign fill_fire_s   = fill_valid && fill_ready;
  assign inv_fire_s    = inv_req && (state_r == ST_RUN);

  // Sweep state and set counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_INIT;
      cnt_r   <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Next-state: INIT and FLUSH walk every set once, then return to RUN.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      ST_INIT, ST_FLUSH: begin
        if (cnt_r == IDX_W'(SETS - 1)) begin
          state_nx_s = ST_RUN;
          cnt_nx_s   = {IDX_W{1'b0}};
        end else begin
          cnt_nx_s = cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RUN: begin
        if (inv_req) begin
          state_nx_s = ST_FLUSH;
          cnt_nx_s   = {IDX_W{1'b0}};
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      default: begin
        state_nx_s = ST_INIT;
        cnt_nx_s   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Per-way tag compare for the lookup set.
  always_comb begin
    match_s = {WAYS{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      match_s[w] = valid_mem[lookup_index][w] && (tag_mem[lookup_index][w] == lookup_tag);
    end
  end

  // More than one match is illegal; the lowest matching way wins regardless.
  assign hit_s     = |match_s;
  assign hit_way_s = lowest_set(match_s);
  assign invalid_s = ~valid_mem[fill_index];

  // Victim: lowest invalid way first, otherwise the PLRU way.
  always_comb begin
    if (|invalid_s) begin
      fill_way = lowest_set(invalid_s);
    end else begin
      fill_way = plru_victim(plru_mem[fill_index]);
    end
  end

  // Array update: sweep clears, fill writes, a lookup hit refreshes PLRU.
  // Fill and lookup are never accepted together, so the writes cannot collide.
  always_ff @(posedge clk) begin
    if (state_r != ST_RUN) begin
      valid_mem[cnt_r] <= {WAYS{1'b0}};
      plru_mem[cnt_r]  <= {PLRU_W{1'b0}};
    end else if (fill_fire_s) begin
      tag_mem[fill_index][fill_way]   <= fill_tag;
      data_mem[fill_index][fill_way]  <= fill_data;
      valid_mem[fill_index][fill_way] <= 1'b1;
      plru_mem[fill_index]            <= plru_touch(plru_mem[fill_index], fill_way);
    end else if (lookup_fire_s && hit_s) begin
      plru_mem[lookup_index] <= plru_touch(plru_mem[lookup_index], hit_way_s);
    end
  end

  // Registered lookup response; way and data read as zero on a miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_way   <= {WAY_W{1'b0}};
      resp_data  <= {LINE_W{1'b0}};
    end else begin
      resp_valid <= lookup_fire_s;
      resp_hit   <= lookup_fire_s && hit_s;
      resp_way   <= (lookup_fire_s && hit_s) ? hit_way_s : {WAY_W{1'b0}};
      resp_data  <= (lookup_fire_s && hit_s) ? data_mem[lookup_index][hit_way_s]
                                             : {LINE_W{1'b0}};
    end
  end

`ifdef CACHE_PERF_CNT_EN
  // Saturating hit counter; an accepted invalidate clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt <= 32'd0;
    end else if (inv_fire_s) begin
      hit_cnt <= 32'd0;
    end else if (resp_valid && resp_hit && (hit_cnt != 32'hFFFF_FFFF)) begin
      hit_cnt <= hit_cnt + 32'd1;
    end
  end

  // Saturating miss counter; an accepted invalidate clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt <= 32'd0;
    end else if (inv_fire_s) begin
      miss_cnt <= 32'd0;
    end else if (resp_valid && !resp_hit && (miss_cnt != 32'hFFFF_FFFF)) begin
      miss_cnt <= miss_cnt + 32'd1;
    end
  end
`else
  logic unused_inv_s;
  assign unused_inv_s = inv_fire_s;
`endif

endmodule
